pipe_reg_chain: RTL and testbench

//   Parametrised multi-stage pipeline register with valid/ready handshake,

---
 rtl/pipe_reg_chain.sv | 140 ++++++++++++++
 tb/tb_pipe_reg_chain.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain
//   Multi-stage pipeline register: WIDTH bits x DEPTH stages with a
//   valid/ready handshake. Empty stages are filled even while the output is
//   stalled, so bubbles collapse. The chain runs at one word per cycle when
//   the output is accepted every cycle.
//
//   Ports
//     clk        rising-edge clock
//     clr        synchronous active-high reset: clears valids, loads RESET_VAL
//     flush      synchronous invalidate of all stages (data held)
//     in_valid   upstream offers in_data
//     in_data    upstream data word
//     in_ready   stage 0 can take a word this cycle
//     out_valid  last stage holds a valid word (registered)
//     out_data   last-stage data register (registered)
//     out_ready  downstream takes the word this cycle
//     occupancy  number of valid stages (registered)
module pipe_reg_chain #(
    parameter int              WIDTH     = 8,
    parameter int              DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    // A zero-stage chain has no meaning; refuse to elaborate it.
    if (DEPTH < 1) begin : g_bad_depth
        $error("pipe_reg_chain: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] valid_r;
    logic [WIDTH-1:0] data_r [DEPTH];
    logic [OCC_W-1:0] occ_r;

    logic [DEPTH-1:0] adv_s;
    logic [DEPTH-1:0] load_s;
    logic [WIDTH-1:0] src_s  [DEPTH];
    logic             in_ready_s;
    logic             accept_s;
    logic             pop_s;

    // Advance chain, evaluated from the output back toward stage 0: a stage
    // may move on when the next stage is empty or is itself moving on.
    always_comb begin
        adv_s            = {DEPTH{1'b0}};
        adv_s[DEPTH-1]   = valid_r[DEPTH-1] & out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv_s[i] = valid_r[i] & (~valid_r[i+1] | adv_s[i+1]);
        end
    end

    // Handshake: input is refused during clr or flush so a word offered then
    // is dropped rather than half-loaded.
    always_comb begin
        in_ready_s = ~flush & ~clr & (~valid_r[0] | adv_s[0]);
        accept_s   = in_valid & in_ready_s;
        pop_s      = valid_r[DEPTH-1] & out_ready;
    end

    // Per-stage load enable and load source (stage 0 loads from the input,
    // every other stage from its predecessor).
    always_comb begin
        load_s    = {DEPTH{1'b0}};
        load_s[0] = accept_s;
        src_s[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            load_s[i] = adv_s[i-1];
            src_s[i]  = data_r[i-1];
        end
    end

    // Valid bits: a load sets the stage, a departure with no refill clears it.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_r <= {DEPTH{1'b0}};
        end else if (flush) begin
            valid_r <= {DEPTH{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (load_s[i]) begin
                    valid_r[i] <= 1'b1;
                end else if (adv_s[i]) begin
                    valid_r[i] <= 1'b0;
                end else begin
                    valid_r[i] <= valid_r[i];
                end
            end
        end
    end

    // Data registers: only loaded on a real transfer, otherwise they keep their
    // last value, including through a flush.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= RESET_VAL;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= data_r[i];
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (load_s[i]) begin
                    data_r[i] <= src_s[i];
                end else begin
                    data_r[i] <= data_r[i];
                end
            end
        end
    end

    // Occupancy counter: +1 per accepted word, -1 per word taken downstream.
    always_ff @(posedge clk) begin
        if (clr) begin
            occ_r <= {OCC_W{1'b0}};
        end else if (flush) begin
            occ_r <= {OCC_W{1'b0}};
        end else begin
            occ_r <= occ_r + OCC_W'(accept_s) - OCC_W'(pop_s);
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = valid_r[DEPTH-1];
    assign out_data  = data_r[DEPTH-1];
    assign occupancy = occ_r;

endmodule

// File: tb/tb_pipe_reg_chain.sv
module tb_pipe_reg_chain;

    logic       clk;
    logic       clr;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [1:0] occupancy;

    int total;
    int bad;

    pipe_reg_chain #(
        .WIDTH    (8),
        .DEPTH    (3),
        .RESET_VAL(8'hA5)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .occupancy(occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       clr;
        logic       flush;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       exp_rdy;   // in_ready before the edge
        logic       exp_ov;    // out_valid after the edge
        logic [7:0] exp_od;    // out_data after the edge
        logic [1:0] exp_occ;   // occupancy after the edge
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic c, input logic f, input logic iv, input logic [7:0] id,
                       input logic ordy, input logic rdy, input logic ov,
                       input logic [7:0] od, input logic [1:0] occ);
        vec_t v;
        v.clr = c; v.flush = f; v.iv = iv; v.id = id; v.ordy = ordy;
        v.exp_rdy = rdy; v.exp_ov = ov; v.exp_od = od; v.exp_occ = occ;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, check in_ready before the rising edge and the
    // registered outputs 1 time unit after it.
    task automatic step(input string tag, input logic c, input logic f, input logic iv,
                        input logic [7:0] id, input logic ordy, input logic rdy,
                        input logic ov, input logic [7:0] od, input logic [1:0] occ);
        @(negedge clk);
        clr = c; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        check({tag, " in_ready"}, 32'(in_ready), 32'(rdy));
        @(posedge clk);
        #1;
        check({tag, " out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, " out_data"}, 32'(out_data), 32'(od));
        check({tag, " occupancy"}, 32'(occupancy), 32'(occ));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clr = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

        //   clr   flush iv    id     ordy  rdy   ov    od     occ
        // reset, then release
        add(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hA5, 2'd0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 2'd0);
        // stalled output: fill with 11,22,33; 44 refused while full
        add(1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'hA5, 2'd1);
        add(1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'hA5, 2'd2);
        add(1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 2'd3);
        add(1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h11, 2'd3);
        // release: 44 accepted while 11 leaves, then drain in order
        add(1'b0, 1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h22, 2'd3);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 2'd2);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 2'd1);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h44, 2'd0);
        // 11 alone in stage 2, output stalled; 22 collapses past the bubble
        add(1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h44, 2'd1);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h44, 2'd1);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 2'd1);
        add(1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 2'd2);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 2'd2);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 2'd2);
        // fill, then flush with 77 offered: 77 never appears
        add(1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 2'd3);
        add(1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'h11, 2'd0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h11, 2'd0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h11, 2'd0);
        // clr and flush together mid-stream: clr wins
        add(1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 8'h11, 2'd1);
        add(1'b0, 1'b0, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 8'h11, 2'd2);
        add(1'b1, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 8'hA5, 2'd0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 2'd0);

        for (int i = 0; i < vq.size(); i++) begin
            step($sformatf("vec%0d", i), vq[i].clr, vq[i].flush, vq[i].iv, vq[i].id,
                 vq[i].ordy, vq[i].exp_rdy, vq[i].exp_ov, vq[i].exp_od, vq[i].exp_occ);
        end

        // Streaming 01..10 with out_ready held high: word accepted at edge k
        // shows at the output after edge k+2, one word per cycle, no gaps.
        for (int k = 0; k < 19; k++) begin
            logic [7:0] od;
            logic       ov;
            int         acc;
            int         emi;
            ov  = (k >= 2) && (k <= 17);
            if (k < 2)       od = 8'hA5;
            else if (k < 18) od = 8'(k - 1);
            else             od = 8'h10;
            acc = (k + 1 < 16) ? k + 1 : 16;
            emi = (k - 2 < 0) ? 0 : ((k - 2 > 16) ? 16 : k - 2);
            step($sformatf("stream%0d", k), 1'b0, 1'b0, (k < 16), 8'(k + 1), 1'b1,
                 1'b1, ov, od, 2'(acc - emi));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
